// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_pkg
// Description : Shared types and defaults for the write-back stage.
//               mem_size_e : load access size / signedness encoding.
//               c_default_xlen / c_default_rbuf_depth : configuration defaults.
//               size_log2  : log2 of the access size in bytes.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package wb_stage_pkg;

    localparam int c_default_xlen       = 32;
    localparam int c_default_rbuf_depth = 2;

    typedef enum logic [2:0] {
        BYTE_S = 3'd0,
        HALF_S = 3'd1,
        WORD_S = 3'd2,
        DWORD  = 3'd3,
        BYTE_U = 3'd4,
        HALF_U = 3'd5,
        WORD_U = 3'd6
    } mem_size_e;

    // The low two encoding bits are log2 of the access size in bytes.
    function automatic logic [1:0] size_log2(input mem_size_e size);
        return size[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_resp_fifo
// Description : Small synchronous FIFO holding data-memory responses that
//               arrive before their load reaches write-back.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_push/i_push_data - enqueue one entry (ignored when full)
//               i_pop              - dequeue head (ignored when empty)
//               o_head_data        - head entry, valid when ~o_empty
//               o_empty/o_full     - occupancy flags
//               o_count            - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module wb_resp_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [WIDTH-1:0] w_mem_d [DEPTH];
    logic [PTR_W-1:0] r_wptr_q, w_wptr_d;
    logic [PTR_W-1:0] r_rptr_q, w_rptr_d;
    logic [CNT_W-1:0] r_cnt_q,  w_cnt_d;
    logic             w_do_push;
    logic             w_do_pop;

    // Explicit wrap keeps the pointers correct for any depth, including 1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty     = (r_cnt_q == '0);
    assign o_full      = (r_cnt_q == CNT_W'(DEPTH));
    assign o_count     = r_cnt_q;
    assign o_head_data = r_mem_q[r_rptr_q];

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;

    always_comb begin
        w_mem_d  = r_mem_q;
        w_wptr_d = r_wptr_q;
        w_rptr_d = r_rptr_q;
        w_cnt_d  = r_cnt_q;
        if (w_do_push) begin
            w_mem_d[r_wptr_q] = i_push_data;
            w_wptr_d          = ptr_inc(r_wptr_q);
        end
        if (w_do_pop) begin
            w_rptr_d = ptr_inc(r_rptr_q);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   w_cnt_d = r_cnt_q + CNT_W'(1);
            2'b01:   w_cnt_d = r_cnt_q - CNT_W'(1);
            default: w_cnt_d = r_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_q  <= '{default: '0};
            r_wptr_q <= '0;
            r_rptr_q <= '0;
            r_cnt_q  <= '0;
        end else begin
            r_mem_q  <= w_mem_d;
            r_wptr_q <= w_wptr_d;
            r_rptr_q <= w_rptr_d;
            r_cnt_q  <= w_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Pipeline write-back stage. Registers the LSU-to-WB bundle,
//               buffers data-memory responses in a RBUF_DEPTH-deep FIFO,
//               aligns/extends load data and drives the register-file write
//               port, the load hazard flag and the forwarding indices.
// Parameters  : XLEN (32 or 64), RBUF_DEPTH (power of two, 1..8),
//               OFS_W (derived byte-offset width).
// Ports       : clk, rst                  - clock, synchronous reset
//               lsu2wb_*                  - incoming stage bundle
//               dmem_resp_valid/ready/data- data-memory response channel
//               ac2wb_stall               - hold stage, suppress commit
//               wb2ac_hazard              - load in WB lacks its data
//               wb_rs1, wb_rs2            - registered source indices
//               wb2rf_wren/waddr/wdata    - register-file write port
//               wb2ac_misalign            - only with WB_MISALIGN_CHK_EN
// Options     : WB_MISALIGN_CHK_EN - flag and suppress misaligned loads.
// Revision    : 1.0 - parametrised successor to the 32-bit write-back unit
// ============================================================================
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter  int XLEN       = c_default_xlen,
    parameter  int RBUF_DEPTH = c_default_rbuf_depth,
    localparam int OFS_W      = $clog2(XLEN / 8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lsu2wb_valid,
    input  logic [31:0]      lsu2wb_pc,
    input  logic [31:0]      lsu2wb_inst,
    input  logic [4:0]       lsu2wb_rs1,
    input  logic [4:0]       lsu2wb_rs2,
    input  logic [4:0]       lsu2wb_rd,
    input  logic             lsu2wb_rf_we,
    input  logic             lsu2wb_rf_rd_sel1,
    input  logic [XLEN-1:0]  lsu2wb_dout,
    input  logic             lsu2wb_mem_valid,
    input  logic [2:0]       lsu2wb_mem_size,
    input  logic [OFS_W-1:0] lsu2wb_mem_addr_offset,
    input  logic             dmem_resp_valid,
    output logic             dmem_resp_ready,
    input  logic [XLEN-1:0]  dmem_resp_data,
    input  logic             ac2wb_stall,
    output logic             wb2ac_hazard,
    output logic [4:0]       wb_rs1,
    output logic [4:0]       wb_rs2,
    output logic             wb2rf_wren,
    output logic [4:0]       wb2rf_waddr,
    output logic [XLEN-1:0]  wb2rf_wdata
`ifdef WB_MISALIGN_CHK_EN
    ,
    output logic             wb2ac_misalign
`endif
);

    localparam int CNT_W = $clog2(RBUF_DEPTH + 1);

    typedef struct packed {
        logic             valid;
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             rf_we;
        logic             rd_sel1;
        logic [XLEN-1:0]  dout;
        logic             mem_valid;
        mem_size_e        mem_size;
        logic [OFS_W-1:0] ofs;
    } stage_t;

    stage_t           r_stage_q, w_stage_d;

    logic             w_need;
    logic             w_data_avail;
    logic             w_pop;
    logic             w_bypass;
    logic             w_push;
    logic             w_fifo_pop;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic [CNT_W-1:0] w_fifo_count;
    logic [XLEN-1:0]  w_head_data;
    logic [XLEN-1:0]  w_rdata;
    logic [OFS_W-1:0] w_ofs_al;
    logic [XLEN-1:0]  w_lane;
    logic [XLEN-1:0]  w_aligned;
    logic             w_misalign;
    logic             w_unused;

    // ------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------
    always_comb begin
        w_stage_d = r_stage_q;
        if (!ac2wb_stall) begin
            w_stage_d.valid     = lsu2wb_valid;
            w_stage_d.pc        = lsu2wb_pc;
            w_stage_d.inst      = lsu2wb_inst;
            w_stage_d.rs1       = lsu2wb_rs1;
            w_stage_d.rs2       = lsu2wb_rs2;
            w_stage_d.rd        = lsu2wb_rd;
            w_stage_d.rf_we     = lsu2wb_rf_we;
            w_stage_d.rd_sel1   = lsu2wb_rf_rd_sel1;
            w_stage_d.dout      = lsu2wb_dout;
            w_stage_d.mem_valid = lsu2wb_mem_valid;
            w_stage_d.mem_size  = mem_size_e'(lsu2wb_mem_size);
            w_stage_d.ofs       = lsu2wb_mem_addr_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_q <= '0;
        end else begin
            r_stage_q <= w_stage_d;
        end
    end

    // ------------------------------------------------------------------
    // Response buffering. The FIFO head always wins over a live beat so
    // responses are consumed in arrival order; a live beat bypasses the
    // FIFO only when it is empty and the load is consuming this cycle.
    // ------------------------------------------------------------------
    assign w_need       = r_stage_q.valid & r_stage_q.mem_valid & r_stage_q.rd_sel1;
    assign w_data_avail = ~w_fifo_empty | dmem_resp_valid;
    assign w_pop        = w_need & w_data_avail & ~ac2wb_stall;
    assign w_bypass     = w_fifo_empty & dmem_resp_valid & w_pop;
    assign w_fifo_pop   = w_pop & ~w_fifo_empty;

    // Ready comes from the registered count only, so a full FIFO never
    // accepts a beat even when its head is being popped.
    assign dmem_resp_ready = ~w_fifo_full;
    assign w_push          = dmem_resp_valid & dmem_resp_ready & ~w_bypass;
    assign w_rdata         = w_fifo_empty ? dmem_resp_data : w_head_data;

    wb_resp_fifo #(
        .WIDTH (XLEN),
        .DEPTH (RBUF_DEPTH)
    ) u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (dmem_resp_data),
        .i_pop       (w_fifo_pop),
        .o_head_data (w_head_data),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_count     (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Load alignment: round the offset down to the access size, shift the
    // selected lane to bit 0, then sign- or zero-extend.
    // ------------------------------------------------------------------
    always_comb begin
        w_ofs_al = r_stage_q.ofs;
        for (int i = 0; i < OFS_W; i++) begin
            if (i < int'(size_log2(r_stage_q.mem_size))) begin
                w_ofs_al[i] = 1'b0;
            end
        end
    end

    assign w_lane = w_rdata >> {w_ofs_al, 3'b000};

    always_comb begin
        w_aligned = w_rdata;
        case (r_stage_q.mem_size)
            BYTE_S:  w_aligned = XLEN'($signed(w_lane[7:0]));
            BYTE_U:  w_aligned = XLEN'(w_lane[7:0]);
            HALF_S:  w_aligned = XLEN'($signed(w_lane[15:0]));
            HALF_U:  w_aligned = XLEN'(w_lane[15:0]);
            WORD_S:  w_aligned = XLEN'($signed(w_lane[31:0]));
            // Zero-extended word is only meaningful on a 64-bit datapath.
            WORD_U:  w_aligned = (XLEN == 64) ? XLEN'(w_lane[31:0]) : w_rdata;
            DWORD:   w_aligned = w_rdata;
            default: w_aligned = w_rdata;
        endcase
    end

`ifdef WB_MISALIGN_CHK_EN
    // Any offset bit cleared by the rounding means the access straddles
    // its natural alignment.
    assign w_misalign     = w_need & (w_ofs_al != r_stage_q.ofs);
    assign wb2ac_misalign = w_misalign;
`else
    assign w_misalign     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb2ac_hazard = w_need & ~w_data_avail;
    // One strobe per instruction: the stage advances on the same edge.
    assign wb2rf_wren   = r_stage_q.valid & r_stage_q.rf_we & ~ac2wb_stall
                        & ~wb2ac_hazard & ~w_misalign;
    assign wb2rf_waddr  = r_stage_q.rd;
    assign wb2rf_wdata  = r_stage_q.rd_sel1 ? w_aligned : r_stage_q.dout;
    assign wb_rs1       = r_stage_q.rs1;
    assign wb_rs2       = r_stage_q.rs2;

    // pc/inst are carried for trace visibility only.
    assign w_unused = ^{r_stage_q.pc, r_stage_q.inst, w_fifo_count, w_lane};

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Scoreboard bench for wb_stage. Instance a is XLEN=32,
//               instance b is XLEN=64; both RBUF_DEPTH=2. Expected commits
//               are queued by the stimulus and checked by per-instance
//               monitors whenever wb2rf_wren is seen.
// Options     : WB_MISALIGN_CHK_EN - also checks wb2ac_misalign.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;
    import wb_stage_pkg::*;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    // instance a (XLEN=32)
    logic        a_valid, a_we, a_sel1, a_memv, a_rv, a_rr, a_stall, a_haz, a_wren;
    logic [31:0] a_pc, a_inst, a_dout, a_rdata, a_wdata;
    logic [4:0]  a_rs1, a_rs2, a_rd, a_wrs1, a_wrs2, a_waddr;
    logic [2:0]  a_size;
    logic [1:0]  a_ofs;
    // instance b (XLEN=64)
    logic        b_valid, b_we, b_sel1, b_memv, b_rv, b_rr, b_stall, b_haz, b_wren;
    logic [31:0] b_pc, b_inst;
    logic [63:0] b_dout, b_rdata, b_wdata;
    logic [4:0]  b_rs1, b_rs2, b_rd, b_wrs1, b_wrs2, b_waddr;
    logic [2:0]  b_size;
    logic [2:0]  b_ofs;
`ifdef WB_MISALIGN_CHK_EN
    logic        a_mis, b_mis;
`endif

    wb_stage #(.XLEN(32), .RBUF_DEPTH(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .lsu2wb_valid(a_valid), .lsu2wb_pc(a_pc), .lsu2wb_inst(a_inst),
        .lsu2wb_rs1(a_rs1), .lsu2wb_rs2(a_rs2), .lsu2wb_rd(a_rd),
        .lsu2wb_rf_we(a_we), .lsu2wb_rf_rd_sel1(a_sel1), .lsu2wb_dout(a_dout),
        .lsu2wb_mem_valid(a_memv), .lsu2wb_mem_size(a_size),
        .lsu2wb_mem_addr_offset(a_ofs),
        .dmem_resp_valid(a_rv), .dmem_resp_ready(a_rr), .dmem_resp_data(a_rdata),
        .ac2wb_stall(a_stall), .wb2ac_hazard(a_haz),
        .wb_rs1(a_wrs1), .wb_rs2(a_wrs2),
        .wb2rf_wren(a_wren), .wb2rf_waddr(a_waddr), .wb2rf_wdata(a_wdata)
`ifdef WB_MISALIGN_CHK_EN
        , .wb2ac_misalign(a_mis)
`endif
    );

    wb_stage #(.XLEN(64), .RBUF_DEPTH(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .lsu2wb_valid(b_valid), .lsu2wb_pc(b_pc), .lsu2wb_inst(b_inst),
        .lsu2wb_rs1(b_rs1), .lsu2wb_rs2(b_rs2), .lsu2wb_rd(b_rd),
        .lsu2wb_rf_we(b_we), .lsu2wb_rf_rd_sel1(b_sel1), .lsu2wb_dout(b_dout),
        .lsu2wb_mem_valid(b_memv), .lsu2wb_mem_size(b_size),
        .lsu2wb_mem_addr_offset(b_ofs),
        .dmem_resp_valid(b_rv), .dmem_resp_ready(b_rr), .dmem_resp_data(b_rdata),
        .ac2wb_stall(b_stall), .wb2ac_hazard(b_haz),
        .wb_rs1(b_wrs1), .wb_rs2(b_wrs2),
        .wb2rf_wren(b_wren), .wb2rf_waddr(b_waddr), .wb2rf_wdata(b_wdata)
`ifdef WB_MISALIGN_CHK_EN
        , .wb2ac_misalign(b_mis)
`endif
    );

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && a_wren) begin
            exp_t e;
            n_vec++;
            if (q_a.size() == 0) begin
                n_err++;
                $display("FAIL commit_a: unexpected write rd=%0d data=%h, none required", a_waddr, a_wdata);
            end else begin
                e = q_a.pop_front();
                if (a_waddr !== e.addr || a_wdata !== e.data[31:0]) begin
                    n_err++;
                    $display("FAIL commit_a: got rd=%0d data=%h, required rd=%0d data=%h",
                             a_waddr, a_wdata, e.addr, e.data[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_wren) begin
            exp_t e;
            n_vec++;
            if (q_b.size() == 0) begin
                n_err++;
                $display("FAIL commit_b: unexpected write rd=%0d data=%h, none required", b_waddr, b_wdata);
            end else begin
                e = q_b.pop_front();
                if (b_waddr !== e.addr || b_wdata !== e.data) begin
                    n_err++;
                    $display("FAIL commit_b: got rd=%0d data=%h, required rd=%0d data=%h",
                             b_waddr, b_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic slot_a(input logic [4:0] rd, input logic we, input logic sel1,
                          input logic memv, input logic [2:0] size,
                          input logic [1:0] ofs, input logic [31:0] dout);
        a_valid = 1'b1; a_rd = rd; a_rs1 = rd + 5'd1; a_rs2 = rd + 5'd2;
        a_we = we; a_sel1 = sel1; a_memv = memv; a_size = size; a_ofs = ofs;
        a_dout = dout; a_pc = a_pc + 32'd4; a_inst = {27'd0, rd};
    endtask

    task automatic clr_a();
        a_valid = 1'b0; a_we = 1'b0; a_sel1 = 1'b0; a_memv = 1'b0;
    endtask

    task automatic slot_b(input logic [4:0] rd, input logic [2:0] size, input logic [2:0] ofs);
        b_valid = 1'b1; b_rd = rd; b_rs1 = rd + 5'd1; b_rs2 = rd + 5'd2;
        b_we = 1'b1; b_sel1 = 1'b1; b_memv = 1'b1; b_size = size; b_ofs = ofs;
        b_pc = b_pc + 32'd4; b_inst = {27'd0, rd};
    endtask

    task automatic clr_b();
        b_valid = 1'b0; b_we = 1'b0; b_sel1 = 1'b0; b_memv = 1'b0;
    endtask

    // Load with its response arriving in the WB cycle (bypass path).
    task automatic load_a(input logic [4:0] rd, input logic [2:0] size, input logic [1:0] ofs,
                          input logic [31:0] data, input logic [31:0] expv, input logic commit);
        slot_a(rd, 1'b1, 1'b1, 1'b1, size, ofs, 32'd0);
        step();
        clr_a();
        a_rv = 1'b1; a_rdata = data;
        if (commit) q_a.push_back('{addr: rd, data: {32'd0, expv}});
        @(negedge clk);
        chk("load_a_hazard", a_haz, 0);
        chk("load_a_rs1", a_wrs1, 64'(rd + 5'd1));
`ifdef WB_MISALIGN_CHK_EN
        chk("load_a_misalign", a_mis, !commit);
`endif
        step();
        a_rv = 1'b0;
    endtask

    task automatic load_b(input logic [4:0] rd, input logic [2:0] size, input logic [2:0] ofs,
                          input logic [63:0] data, input logic [63:0] expv, input logic commit);
        slot_b(rd, size, ofs);
        step();
        clr_b();
        b_rv = 1'b1; b_rdata = data;
        if (commit) q_b.push_back('{addr: rd, data: expv});
        @(negedge clk);
        chk("load_b_hazard", b_haz, 0);
        chk("load_b_rs2", b_wrs2, 64'(rd + 5'd2));
`ifdef WB_MISALIGN_CHK_EN
        chk("load_b_misalign", b_mis, !commit);
`endif
        step();
        b_rv = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        a_valid = 0; a_pc = 0; a_inst = 0; a_rs1 = 0; a_rs2 = 0; a_rd = 0; a_we = 0;
        a_sel1 = 0; a_dout = 0; a_memv = 0; a_size = 0; a_ofs = 0; a_rv = 0;
        a_rdata = 0; a_stall = 0;
        b_valid = 0; b_pc = 0; b_inst = 0; b_rs1 = 0; b_rs2 = 0; b_rd = 0; b_we = 0;
        b_sel1 = 0; b_dout = 0; b_memv = 0; b_size = 0; b_ofs = 0; b_rv = 0;
        b_rdata = 0; b_stall = 0;
        step();
        step();
        @(negedge clk);
        chk("rst_ready_a", a_rr, 1);
        chk("rst_wren_a", a_wren, 0);
        chk("rst_waddr_a", a_waddr, 0);
        chk("rst_wdata_a", a_wdata, 0);
        chk("rst_hazard_a", a_haz, 0);
        chk("rst_rs_a", {a_wrs1, a_wrs2}, 0);
        chk("rst_ready_b", b_rr, 1);
        chk("rst_wdata_b", b_wdata, 0);
        step();
        rst = 1'b0;

        // Alignment patterns, response in the same cycle.
        load_a(5'd5,  BYTE_S, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF, 1'b1);
        load_a(5'd6,  BYTE_U, 2'd3, 32'h80FF7F01, 32'h00000080, 1'b1);
        load_a(5'd7,  HALF_S, 2'd2, 32'h80FF7F01, 32'hFFFF80FF, 1'b1);
        load_a(5'd8,  HALF_U, 2'd0, 32'h80FF7F01, 32'h00007F01, 1'b1);
        load_a(5'd9,  WORD_S, 2'd0, 32'h80FF7F01, 32'h80FF7F01, 1'b1);
        load_a(5'd10, BYTE_S, 2'd0, 32'h80FF7F01, 32'h00000001, 1'b1);
`ifdef WB_MISALIGN_CHK_EN
        load_a(5'd11, HALF_S, 2'd3, 32'h80FF7F01, 32'h0, 1'b0);
`else
        load_a(5'd11, HALF_S, 2'd3, 32'h80FF7F01, 32'hFFFF80FF, 1'b1);
`endif

        // ALU result write-back and a non-writing instruction.
        slot_a(5'd12, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 32'h12345678);
        step();
        slot_a(5'd13, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'hDEADDEAD);
        q_a.push_back('{addr: 5'd12, data: 64'h12345678});
        @(negedge clk);
        chk("alu_hazard", a_haz, 0);
        step();
        clr_a();
        @(negedge clk);
        chk("nowrite_wren", a_wren, 0);
        step();

        // Response three cycles before the load reaches WB.
        a_rv = 1'b1; a_rdata = 32'h0000ABCD;
        @(negedge clk);
        chk("early_ready", a_rr, 1);
        step();
        a_rv = 1'b0;
        step();
        slot_a(5'd14, 1'b1, 1'b1, 1'b1, HALF_U, 2'd0, 32'd0);
        step();
        clr_a();
        q_a.push_back('{addr: 5'd14, data: 64'h0000ABCD});
        @(negedge clk);
        chk("early_hazard", a_haz, 0);
        step();

        // Load waiting four cycles for its response.
        slot_a(5'd15, 1'b1, 1'b1, 1'b1, WORD_S, 2'd0, 32'd0);
        step();
        clr_a();
        a_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wait_hazard", a_haz, 1);
            chk("wait_wren", a_wren, 0);
            step();
        end
        a_stall = 1'b0;
        a_rv = 1'b1; a_rdata = 32'hCAFEF00D;
        q_a.push_back('{addr: 5'd15, data: 64'hCAFEF00D});
        @(negedge clk);
        chk("wait_release_hazard", a_haz, 0);
        step();
        a_rv = 1'b0;
        @(negedge clk);
        chk("wait_after_wren", a_wren, 0);
        step();

        // FIFO full: three back-to-back beats, third held by memory side.
        a_rv = 1'b1; a_rdata = 32'h11111111;
        @(negedge clk);
        chk("full_ready_1", a_rr, 1);
        step();
        a_rdata = 32'h22222222;
        @(negedge clk);
        chk("full_ready_2", a_rr, 1);
        step();
        a_rdata = 32'h33333333;
        @(negedge clk);
        chk("full_ready_3", a_rr, 0);
        slot_a(5'd16, 1'b1, 1'b1, 1'b1, WORD_S, 2'd0, 32'd0);
        step();
        slot_a(5'd17, 1'b1, 1'b1, 1'b1, WORD_S, 2'd0, 32'd0);
        q_a.push_back('{addr: 5'd16, data: 64'h11111111});
        @(negedge clk);
        chk("full_pop_ready", a_rr, 0);
        step();
        slot_a(5'd18, 1'b1, 1'b1, 1'b1, WORD_S, 2'd0, 32'd0);
        q_a.push_back('{addr: 5'd17, data: 64'h22222222});
        @(negedge clk);
        chk("pushpop_ready", a_rr, 1);
        step();
        a_rv = 1'b0;
        clr_a();
        q_a.push_back('{addr: 5'd18, data: 64'h33333333});
        @(negedge clk);
        chk("drain_hazard", a_haz, 0);
        step();
        @(negedge clk);
        chk("drain_ready", a_rr, 1);
        step();

        // Stall held two cycles while the response arrives.
        slot_a(5'd19, 1'b1, 1'b1, 1'b1, BYTE_U, 2'd1, 32'd0);
        step();
        clr_a();
        a_stall = 1'b1;
        a_rv = 1'b1; a_rdata = 32'h0000AA00;
        @(negedge clk);
        chk("stall1_wren", a_wren, 0);
        chk("stall1_hazard", a_haz, 0);
        step();
        a_rv = 1'b0;
        @(negedge clk);
        chk("stall2_wren", a_wren, 0);
        chk("stall2_hazard", a_haz, 0);
        step();
        a_stall = 1'b0;
        q_a.push_back('{addr: 5'd19, data: 64'h000000AA});
        @(negedge clk);
        chk("stall_release_hazard", a_haz, 0);
        step();
        @(negedge clk);
        chk("stall_once_wren", a_wren, 0);
        step();

        // Reset mid-operation flushes the buffered response.
        a_rv = 1'b1; a_rdata = 32'hDEADBEEF;
        step();
        a_rv = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", a_rr, 1);
        chk("midrst_hazard", a_haz, 0);
        slot_a(5'd20, 1'b1, 1'b1, 1'b1, WORD_S, 2'd0, 32'd0);
        step();
        clr_a();
        a_stall = 1'b1;
        @(negedge clk);
        chk("midrst_flushed", a_haz, 1);
        step();
        a_stall = 1'b0;
        a_rv = 1'b1; a_rdata = 32'h0BADF00D;
        q_a.push_back('{addr: 5'd20, data: 64'h0BADF00D});
        step();
        a_rv = 1'b0;

        // 64-bit datapath.
        load_b(5'd1, WORD_U, 3'd4, 64'h8000000000000001, 64'h0000000080000000, 1'b1);
        load_b(5'd2, WORD_S, 3'd4, 64'h8000000000000001, 64'hFFFFFFFF80000000, 1'b1);
        load_b(5'd3, DWORD,  3'd0, 64'h8000000000000001, 64'h8000000000000001, 1'b1);
        load_b(5'd4, WORD_U, 3'd0, 64'h8000000000000001, 64'h0000000000000001, 1'b1);
        load_b(5'd5, HALF_S, 3'd6, 64'h8000000000000001, 64'hFFFFFFFFFFFF8000, 1'b1);
`ifdef WB_MISALIGN_CHK_EN
        load_b(5'd6, HALF_S, 3'd1, 64'h000000000000F234, 64'h0, 1'b0);
`else
        load_b(5'd6, HALF_S, 3'd1, 64'h000000000000F234, 64'hFFFFFFFFFFFFF234, 1'b1);
`endif
        // The previous response must have been consumed, not buffered.
        slot_b(5'd7, DWORD, 3'd0);
        step();
        clr_b();
        b_stall = 1'b1;
        @(negedge clk);
        chk("b_consumed_hazard", b_haz, 1);
        step();
        b_stall = 1'b0;
        b_rv = 1'b1; b_rdata = 64'h0123456789ABCDEF;
        q_b.push_back('{addr: 5'd7, data: 64'h0123456789ABCDEF});
        step();
        b_rv = 1'b0;
        step();
        step();

        chk("pending_a", 64'(q_a.size()), 0);
        chk("pending_b", 64'(q_b.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
